// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader.
// Default geometry and FSM state encoding, also used by the instruction memory.
package inst_mem_loader_pkg;

    // Default instruction-memory word-address width and depth
    localparam int IML_ADDR_W = 6;
    localparam int IML_DEPTH  = 64;

    // Loader FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } iml_state_t;

endpackage

// File: rtl/inst_mem_loader.sv
// Instruction-memory loader: packs a little-endian byte stream into
// 32-bit words and writes them to consecutive addresses, holding the CPU.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int ADDR_W = IML_ADDR_W,
    parameter int DEPTH  = IML_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold
);

    localparam int CW = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_W = CW'(DEPTH);
    localparam logic [ADDR_W:0] ONE_W   = CW'(1);

    iml_state_t        state;
    logic [ADDR_W:0]   left;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        byte_cnt;
    logic [23:0]       part_q;
    logic [ADDR_W:0]   wc_sat;

    // Requests beyond the memory size are clipped so a load never wraps onto itself
    always_comb begin
        wc_sat = word_count;
        if (word_count > DEPTH_W) begin
            wc_sat = DEPTH_W;
        end
    end

    // Loader FSM with byte assembly and registered memory-write port
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            left      <= '0;
            addr      <= '0;
            byte_cnt  <= '0;
            part_q    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        left     <= wc_sat;
                        addr     <= '0;
                        byte_cnt <= '0;
                        part_q   <= '0;
                        if (wc_sat == '0) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            done  <= 1'b0;
                            state <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (in_valid) begin
                        if (byte_cnt == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= addr;
                            mem_wdata <= {in_byte, part_q};
                            byte_cnt  <= '0;
                            part_q    <= '0;
                            state     <= ST_WRITE;
                        end else begin
                            part_q[{byte_cnt, 3'b000} +: 8] <= in_byte;
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                ST_WRITE: begin
                    addr <= addr + 1'b1;
                    left <= left - ONE_W;
                    if (left == ONE_W) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_COLLECT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Status decodes straight from the state register
    always_comb begin
        in_ready = (state == ST_COLLECT);
        busy     = (state == ST_COLLECT) || (state == ST_WRITE);
        cpu_hold = ~done;
    end

endmodule
